// File: rtl/maze_grid_renderer.sv
// Maze-state pixel source for the VGA driver: double-buffered cell map written over a
// valid/ready port, copied to the display map at the first blanking line, rendered as RGB332.
module maze_grid_renderer #(
  parameter int          GRID_COLS      = 5,
  parameter int          GRID_ROWS      = 4,
  parameter int          CELL_SHIFT     = 6,
  parameter int          VIS_H          = 288,
  parameter logic [7:0]  COL_UNEXPLORED = 8'h00,
  parameter logic [7:0]  COL_EXPLORED   = 8'h1C,
  parameter logic [7:0]  COL_WALL       = 8'hE0,
  parameter logic [7:0]  COL_ROBOT      = 8'hFC,
  parameter logic [7:0]  COL_GRIDLINE   = 8'h92,
  parameter logic [7:0]  COL_BG         = 8'h03
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [9:0] PIXEL_X,
  input  logic [9:0] PIXEL_Y,
  output logic [7:0] PIXEL_COLOR,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [2:0] WR_COL,
  input  logic [1:0] WR_ROW,
  input  logic [1:0] WR_STATE,
  input  logic       CLEAR,
  output logic       WR_ERR,
  output logic       FRAME_COMMIT
);

  logic [1:0] shadow_q  [GRID_ROWS][GRID_COLS];
  logic [1:0] display_q [GRID_ROWS][GRID_COLS];
  logic       ready_q;
  logic       dirty_q;
  logic       err_q;
  logic [7:0] color_q;
  logic [7:0] color_d;

  logic       commit_c;
  logic       wr_fire;
  logic       wr_in_range;
  logic [9:0] cell_col;
  logic [9:0] cell_row;
  logic       in_grid;
  logic       on_line;
  logic [1:0] cell_state;

  function automatic logic [7:0] state_color(input logic [1:0] st);
    case (st)
      2'd0:    state_color = COL_UNEXPLORED;
      2'd1:    state_color = COL_EXPLORED;
      2'd2:    state_color = COL_WALL;
      default: state_color = COL_ROBOT;
    endcase
  endfunction

  // The copy owns the commit cycle, so the write port stalls for exactly that cycle.
  assign commit_c     = dirty_q && (PIXEL_Y == 10'(VIS_H)) && (PIXEL_X == 10'd0);
  assign WR_READY     = ready_q && !commit_c;
  assign FRAME_COMMIT = commit_c;
  assign WR_ERR       = err_q;
  assign PIXEL_COLOR  = color_q;

  assign wr_fire     = WR_VALID && WR_READY;
  assign wr_in_range = ({1'b0, WR_COL} < 4'(GRID_COLS)) && ({1'b0, WR_ROW} < 3'(GRID_ROWS));

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      ready_q <= 1'b0;
      dirty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (wr_fire && !wr_in_range)
        err_q <= 1'b1;
      // A clear in the commit cycle lands after the copy, so the map stays dirty.
      if (CLEAR)
        dirty_q <= 1'b1;
      else if (commit_c)
        dirty_q <= 1'b0;
      else if (wr_fire && wr_in_range)
        dirty_q <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int r = 0; r < GRID_ROWS; r++)
        for (int c = 0; c < GRID_COLS; c++) begin
          shadow_q[r][c]  <= 2'd0;
          display_q[r][c] <= 2'd0;
        end
    end else begin
      if (commit_c)
        for (int r = 0; r < GRID_ROWS; r++)
          for (int c = 0; c < GRID_COLS; c++)
            display_q[r][c] <= shadow_q[r][c];
      for (int r = 0; r < GRID_ROWS; r++)
        for (int c = 0; c < GRID_COLS; c++)
          if (CLEAR)
            shadow_q[r][c] <= 2'd0;
          else if (wr_fire && wr_in_range && (WR_ROW == 2'(r)) && (WR_COL == 3'(c)))
            shadow_q[r][c] <= WR_STATE;
    end
  end

  // Render stage: pixel coordinate -> cell lookup -> colour, registered once.
  assign cell_col = PIXEL_X >> CELL_SHIFT;
  assign cell_row = PIXEL_Y >> CELL_SHIFT;
  assign in_grid  = (cell_col < 10'(GRID_COLS)) && (cell_row < 10'(GRID_ROWS));
  assign on_line  = (PIXEL_X[CELL_SHIFT-1:0] == '0) || (PIXEL_Y[CELL_SHIFT-1:0] == '0);

  always_comb begin
    cell_state = 2'd0;
    for (int r = 0; r < GRID_ROWS; r++)
      for (int c = 0; c < GRID_COLS; c++)
        if ((cell_row == 10'(r)) && (cell_col == 10'(c)))
          cell_state = display_q[r][c];
  end

  always_comb begin
    color_d = COL_BG;
    if (in_grid)
      color_d = on_line ? COL_GRIDLINE : state_color(cell_state);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      color_q <= 8'h00;
    else
      color_q <= color_d;
  end

endmodule

// File: tb/tb_maze_grid_renderer.sv
// Directed bench for maze_grid_renderer: pixel coordinates are driven directly and
// expected colours are hand-computed from the cell geometry (64 px cells, 5x4 grid).
module tb_maze_grid_renderer;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] px = 10'd0;
  logic [9:0] py = 10'd0;
  logic [7:0] color;
  logic       wv = 1'b0;
  logic       ready;
  logic [2:0] wc = 3'd0;
  logic [1:0] wrw = 2'd0;
  logic [1:0] ws = 2'd0;
  logic       clr = 1'b0;
  logic       err;
  logic       commit;

  int errors = 0;
  int checks = 0;

  maze_grid_renderer dut (
    .CLOCK(CLOCK), .RESET(RESET), .PIXEL_X(px), .PIXEL_Y(py), .PIXEL_COLOR(color),
    .WR_VALID(wv), .WR_READY(ready), .WR_COL(wc), .WR_ROW(wrw), .WR_STATE(ws),
    .CLEAR(clr), .WR_ERR(err), .FRAME_COMMIT(commit)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [7:0] exp);
    @(negedge CLOCK);
    px = 10'(x);
    py = 10'(y);
    @(posedge CLOCK);
    #1;
    chk(tag, color, exp);
  endtask

  task automatic wr(input int c, input int r, input int s, input logic with_clr);
    logic done;
    logic rdy;
    @(negedge CLOCK);
    wv = 1'b1; wc = 3'(c); wrw = 2'(r); ws = 2'(s); clr = with_clr;
    done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) begin
      #1;
      rdy = ready;
      @(posedge CLOCK);
      if (rdy) done = 1'b1;
    end
    @(negedge CLOCK);
    wv = 1'b0; clr = 1'b0;
    if (!done) chk("wr_timeout", 0, 1);
  endtask

  task automatic commit_pt(input string tag, input logic exp);
    @(negedge CLOCK);
    px = 10'd0;
    py = 10'd288;
    #1;
    chk({tag, "_pulse"}, commit, exp);
    chk({tag, "_ready"}, ready, !exp);
    @(posedge CLOCK);
    @(negedge CLOCK);
    py = 10'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_color", color, 8'h00);
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_commit", commit, 0);
    @(negedge CLOCK);
    RESET = 1'b0;
    #1;
    chk("ready_before_edge", ready, 0);
    @(posedge CLOCK);
    #1;
    chk("ready_after_edge", ready, 1);

    // Empty frame
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        pix("empty_cell", c * 64 + 32, r * 64 + 32, 8'h00);
    pix("corner_gridline", 0, 0, 8'h92);
    pix("vline", 64, 100, 8'h92);
    pix("bg_right", 330, 10, 8'h03);
    pix("bg_below", 100, 256, 8'h03);
    commit_pt("clean_commit", 1'b0);

    // Write then commit
    wr(2, 1, 2, 1'b0);
    pix("same_frame", 160, 100, 8'h00);
    commit_pt("commit1", 1'b1);
    pix("next_frame", 160, 100, 8'hE0);
    commit_pt("commit1_again", 1'b0);

    // Write held across the commit cycle
    wr(0, 0, 1, 1'b0);
    @(negedge CLOCK);
    px = 10'd0; py = 10'd288;
    wv = 1'b1; wc = 3'd3; wrw = 2'd2; ws = 2'd3;
    #1;
    chk("hold_ready_commit", ready, 0);
    chk("hold_pulse", commit, 1);
    @(posedge CLOCK);
    #1;
    chk("hold_ready_after", ready, 1);
    chk("hold_pulse_after", commit, 0);
    @(posedge CLOCK);
    @(negedge CLOCK);
    wv = 1'b0; py = 10'd0;
    pix("held_not_yet", 224, 160, 8'h00);
    pix("pre_commit_cell", 32, 32, 8'h1C);
    commit_pt("commit_held", 1'b1);
    pix("held_visible", 224, 160, 8'hFC);

    // Fill, then clear with a coincident write
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        wr(c, r, 3, 1'b0);
    chk("fill_err", err, 0);
    commit_pt("commit_fill", 1'b1);
    pix("fill_last", 288, 224, 8'hFC);
    pix("fill_first", 32, 32, 8'hFC);
    wr(0, 0, 1, 1'b1);
    chk("clear_err", err, 0);
    pix("clear_pending", 32, 32, 8'hFC);
    commit_pt("commit_clear", 1'b1);
    pix("cleared_00", 32, 32, 8'h00);
    pix("cleared_last", 288, 224, 8'h00);

    // CLEAR in the commit cycle: display gets pre-clear data, map stays dirty
    wr(1, 1, 2, 1'b0);
    @(negedge CLOCK);
    px = 10'd0; py = 10'd288; clr = 1'b1;
    #1;
    chk("clr_commit_pulse", commit, 1);
    @(posedge CLOCK);
    @(negedge CLOCK);
    clr = 1'b0; py = 10'd0;
    pix("clr_commit_pre", 96, 96, 8'hE0);
    commit_pt("clr_still_dirty", 1'b1);
    pix("clr_commit_post", 96, 96, 8'h00);

    // Out-of-range column
    wr(6, 0, 1, 1'b0);
    chk("err_set", err, 1);
    commit_pt("err_no_commit", 1'b0);
    pix("err_display", 32, 32, 8'h00);
    chk("err_sticky", err, 1);

    // Reset mid-frame with a pending write
    wr(0, 0, 3, 1'b0);
    commit_pt("pre_reset_commit", 1'b1);
    wr(0, 1, 2, 1'b0);
    pix("pre_reset_pix", 32, 32, 8'hFC);
    RESET = 1'b1;
    #1;
    chk("async_rst_color", color, 8'h00);
    chk("async_rst_err", err, 0);
    chk("async_rst_ready", ready, 0);
    @(negedge CLOCK);
    RESET = 1'b0;
    pix("post_rst_00", 32, 32, 8'h00);
    pix("post_rst_10", 32, 96, 8'h00);
    commit_pt("post_rst_commit", 1'b0);
    pix("post_rst_grid", 0, 0, 8'h92);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
